// File: rtl/flappy_pkg.sv
// Shared types and constants for the pipe field and game sequencing.
// Holds the game state encoding, screen geometry and parameter defaults.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int NUM_PIPES = 4;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;

  localparam int PIPE_W_D       = 24;
  localparam int GAP_HALF_D     = 50;
  localparam int SPACING_D      = 160;
  localparam int SPEED_D        = 2;
  localparam int GAP_MIN_D      = 120;
  localparam int GAP_RANGE_D    = 240;
  localparam int GROUND_Y_D     = SCREEN_H - 5;
  localparam int DYING_FRAMES_D = 60;
  localparam logic [15:0] LFSR_SEED_D = 16'hACE1;

  // Pipes start just off the right edge, evenly spaced.
  function automatic logic [NUM_PIPES-1:0][12:0] pipe_home(
    input int pw,
    input int sp
  );
    logic [NUM_PIPES-1:0][12:0] x;
    for (int i = 0; i < NUM_PIPES; i++) begin
      x[i] = 13'(SCREEN_W + pw + i * sp);
    end
    return x;
  endfunction

  // Two-digit BCD increment, saturating at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99) begin
      r = s;
    end else if (s[3:0] == 4'd9) begin
      r = {s[7:4] + 4'd1, 4'd0};
    end else begin
      r = {s[7:4], s[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_scheduler_if.sv
// Bird inputs and pipe/score outputs between game logic and the mapper.
// master drives the bird and timing, slave is the scheduler.
interface pipe_scheduler_if;
  import flappy_pkg::*;

  logic        frame_tick;
  logic        start;
  logic [9:0]  BirdX;
  logic [9:0]  BirdY;
  logic [9:0]  Bird_size;

  logic [NUM_PIPES-1:0][12:0] pipeX;
  logic [NUM_PIPES-1:0][12:0] pipeWidth;
  logic [NUM_PIPES-1:0][12:0] pipeGapSize;
  logic [NUM_PIPES-1:0][12:0] pipeGapLocation;
  logic [7:0]  score;
  game_state_t game_state;
  logic        game_over;

  modport master (
    output frame_tick, start, BirdX, BirdY, Bird_size,
    input  pipeX, pipeWidth, pipeGapSize, pipeGapLocation,
    input  score, game_state, game_over
  );

  modport slave (
    input  frame_tick, start, BirdX, BirdY, Bird_size,
    output pipeX, pipeWidth, pipeGapSize, pipeGapLocation,
    output score, game_state, game_over
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Source of pseudo-random gap centres for recycled pipes.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [15:0] q
);

  logic [15:0] q_q;

  // Shift left one place every cycle, feedback into bit 0.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      q_q <= SEED;
    end else begin
      q_q <= {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_scheduler.sv
// Scrolls and recycles the pipe field, keeps BCD score, detects
// collisions and sequences IDLE/RUN/DYING/OVER.
module pipe_scheduler
  import flappy_pkg::*;
#(
  parameter int PIPE_W       = PIPE_W_D,
  parameter int GAP_HALF     = GAP_HALF_D,
  parameter int SPACING      = SPACING_D,
  parameter int SPEED        = SPEED_D,
  parameter int GAP_MIN      = GAP_MIN_D,
  parameter int GAP_RANGE    = GAP_RANGE_D,
  parameter int GROUND_Y     = GROUND_Y_D,
  parameter int DYING_FRAMES = DYING_FRAMES_D,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_D
) (
  input logic Clk,
  input logic Reset,
  pipe_scheduler_if.slave bus
);

  localparam logic [12:0] PW  = 13'(PIPE_W);
  localparam logic [12:0] GH  = 13'(GAP_HALF);
  localparam logic [12:0] SPC = 13'(SPACING);
  localparam logic [12:0] SP  = 13'(SPEED);
  localparam logic [12:0] GY  = 13'(GROUND_Y);
  localparam int CW = $clog2(DYING_FRAMES + 1);
  localparam logic [NUM_PIPES-1:0][12:0] X_HOME =
    pipe_home(PIPE_W, SPACING);
  localparam logic [NUM_PIPES-1:0][12:0] G_HOME =
    {NUM_PIPES{13'(SCREEN_H / 2)}};

  logic [15:0] lfsr_q;
  logic        lfsr_unused;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .q     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:8];

  logic [NUM_PIPES-1:0][12:0] px_q, px_d;
  logic [NUM_PIPES-1:0][12:0] gp_q, gp_d;
  game_state_t st_q;
  logic [7:0]  score_q;
  logic        over_q;
  logic [CW-1:0] cnt_q;

  logic [12:0] bx, by, bs;
  logic [7:0]  r;
  logic [12:0] new_gap;
  logic [NUM_PIPES-1:0] hit, pass, rec;
  logic        crash, scored;

  assign bx = {3'b000, bus.BirdX};
  assign by = {3'b000, bus.BirdY};
  assign bs = {3'b000, bus.Bird_size};

  assign r = lfsr_q[7:0];
  assign new_gap = 13'(GAP_MIN) + ((r >= 8'(GAP_RANGE))
                 ? {5'b0, r - 8'(GAP_RANGE)} : {5'b0, r});

  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    localparam int P = (i + NUM_PIPES - 1) % NUM_PIPES;
    logic x_ovl, y_out;
    assign x_ovl = (bx + bs > px_q[i] - PW)
                && (bx - bs < px_q[i] + PW);
    assign y_out = (by - bs < gp_q[i] - GH)
                || (by + bs > gp_q[i] + GH);
    assign hit[i]  = x_ovl && y_out;
    assign pass[i] = (px_q[i] + PW >= bx)
                  && (px_q[i] + PW - SP < bx);
    assign rec[i]  = px_q[i] < PW + SP;
    assign px_d[i] = rec[i] ? px_q[P] + SPC - SP
                            : px_q[i] - SP;
    assign gp_d[i] = rec[i] ? new_gap : gp_q[i];
  end

  assign crash  = (by + bs >= GY) || (|hit);
  assign scored = |pass;

  // Game FSM; pipes, score and flags are all registered here.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st_q    <= IDLE;
      score_q <= 8'h00;
      over_q  <= 1'b0;
      cnt_q   <= '0;
      px_q    <= X_HOME;
      gp_q    <= G_HOME;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (bus.start) begin
            st_q    <= RUN;
            score_q <= 8'h00;
          end
        end
        RUN: begin
          if (bus.frame_tick) begin
            if (crash) begin
              st_q  <= DYING;
              cnt_q <= '0;
            end else begin
              px_q <= px_d;
              gp_q <= gp_d;
              if (scored) score_q <= bcd_inc(score_q);
            end
          end
        end
        DYING: begin
          if (bus.frame_tick) begin
            if (cnt_q == CW'(DYING_FRAMES - 1)) begin
              st_q   <= OVER;
              over_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        OVER: begin
          if (bus.start) begin
            st_q   <= IDLE;
            over_q <= 1'b0;
            px_q   <= X_HOME;
            gp_q   <= G_HOME;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign bus.pipeX           = px_q;
  assign bus.pipeGapLocation = gp_q;
  assign bus.pipeWidth       = {NUM_PIPES{PW}};
  assign bus.pipeGapSize     = {NUM_PIPES{GH}};
  assign bus.score           = score_q;
  assign bus.game_state      = st_q;
  assign bus.game_over       = over_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler: vector table over a long run
// plus hand sequences for death, restart and mid-run reset.
module tb_pipe_scheduler;
  import flappy_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_scheduler_if bus();

  pipe_scheduler dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  int pass_n = 0;
  int total_n = 0;

  logic [15:0] m_lfsr;
  logic [7:0]  last_r;

  // Reference LFSR stepping alongside the design.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 16'hACE1;
    else m_lfsr <= {m_lfsr[14:0],
                    m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct {
    int n;
    int x0, x1, x2, x3;
    int sc;
    bit chk_x;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int n, int x0, int x1, int x2,
                              int x3, int sc, bit cx);
    vec_t v;
    v.n = n; v.x0 = x0; v.x1 = x1; v.x2 = x2; v.x3 = x3;
    v.sc = sc; v.chk_x = cx;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic int gap_of(input logic [7:0] rv);
    int o;
    o = (rv >= 8'd240) ? int'(rv) - 240 : int'(rv);
    return 120 + o;
  endfunction

  task automatic tick();
    @(negedge clk);
    bus.frame_tick = 1'b1;
    last_r = m_lfsr[7:0];
    @(negedge clk);
    bus.frame_tick = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Keep the bird inside the gap of whichever pipe is near it.
  task automatic steer();
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (bus.pipeX[i] > 13'd40 && bus.pipeX[i] < 13'd160)
        bus.BirdY = bus.pipeGapLocation[i][9:0];
    end
  endtask

  task automatic chk_home(input string tag);
    for (int i = 0; i < NUM_PIPES; i++) begin
      chk($sformatf("%s_x%0d", tag, i), bus.pipeX[i], 664 + 160 * i);
      chk($sformatf("%s_g%0d", tag, i), bus.pipeGapLocation[i], 240);
    end
  endtask

  int n;
  int gap_exp;
  int pre0, pre3;

  initial begin
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.BirdX      = 10'd100;
    bus.BirdY      = 10'd240;
    bus.Bird_size  = 10'd12;
    gap_exp = -1;

    tbl.push_back(mk(1,    662, 822, 982, 1142, 'h00, 1));
    tbl.push_back(mk(294,   76, 236, 396,  556, 'h00, 1));
    tbl.push_back(mk(295,   74, 234, 394,  554, 'h01, 1));
    tbl.push_back(mk(320,   24, 184, 344,  504, 'h01, 1));
    tbl.push_back(mk(321,  662, 182, 342,  502, 'h01, 1));
    tbl.push_back(mk(374,  556,  76, 236,  396, 'h01, 1));
    tbl.push_back(mk(375,  554,  74, 234,  394, 'h02, 1));
    tbl.push_back(mk(934,    0,   0,   0,    0, 'h08, 0));
    tbl.push_back(mk(935,    0,   0,   0,    0, 'h09, 0));
    tbl.push_back(mk(1014,   0,   0,   0,    0, 'h09, 0));
    tbl.push_back(mk(1015,   0,   0,   0,    0, 'h10, 0));
    tbl.push_back(mk(8134,   0,   0,   0,    0, 'h98, 0));
    tbl.push_back(mk(8135,   0,   0,   0,    0, 'h99, 0));
    tbl.push_back(mk(8216,   0,   0,   0,    0, 'h99, 0));

    repeat (2) @(negedge clk);
    chk("lfsr_seed", dut.lfsr_q, 'hACE1);
    rst = 1'b0;
    chk_home("rst");
    chk("rst_score", bus.score, 0);
    chk("rst_state", int'(bus.game_state), 0);
    chk("rst_over", bus.game_over, 0);
    chk("pipe_w", bus.pipeWidth[2], 24);
    chk("gap_sz", bus.pipeGapSize[1], 50);

    tick();
    chk("idle_hold_x0", bus.pipeX[0], 664);
    chk("idle_state", int'(bus.game_state), 0);

    @(negedge clk);
    bus.start = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.frame_tick = 1'b0;
    chk("st_tick_state", int'(bus.game_state), 1);
    chk("st_tick_x0", bus.pipeX[0], 664);

    n = 0;
    foreach (tbl[k]) begin
      while (n < tbl[k].n) begin
        steer();
        tick();
        n++;
        if (n == 321) gap_exp = gap_of(last_r);
      end
      chk($sformatf("v%0d_score", tbl[k].n), bus.score, tbl[k].sc);
      chk($sformatf("v%0d_state", tbl[k].n),
          int'(bus.game_state), 1);
      if (tbl[k].chk_x) begin
        chk($sformatf("v%0d_x0", tbl[k].n), bus.pipeX[0], tbl[k].x0);
        chk($sformatf("v%0d_x1", tbl[k].n), bus.pipeX[1], tbl[k].x1);
        chk($sformatf("v%0d_x2", tbl[k].n), bus.pipeX[2], tbl[k].x2);
        chk($sformatf("v%0d_x3", tbl[k].n), bus.pipeX[3], tbl[k].x3);
      end
      if (tbl[k].n == 321) begin
        chk("recyc_gap", bus.pipeGapLocation[0], gap_exp);
        chk("recyc_g1", bus.pipeGapLocation[1], 240);
      end
    end

    pre0 = int'(bus.pipeX[0]);
    pre3 = int'(bus.pipeX[3]);
    pulse_start();
    chk("run_start_state", int'(bus.game_state), 1);
    chk("run_start_score", bus.score, 'h99);
    chk("run_start_x0", bus.pipeX[0], pre0);

    bus.BirdY = 10'd470;
    bus.Bird_size = 10'd6;
    tick();
    chk("gnd_state", int'(bus.game_state), 2);
    chk("gnd_x0", bus.pipeX[0], pre0);
    chk("gnd_x3", bus.pipeX[3], pre3);
    chk("gnd_score", bus.score, 'h99);
    repeat (59) tick();
    chk("dying59_state", int'(bus.game_state), 2);
    chk("dying59_x0", bus.pipeX[0], pre0);
    tick();
    chk("over_state", int'(bus.game_state), 3);
    chk("over_flag", bus.game_over, 1);
    chk("over_score", bus.score, 'h99);
    pulse_start();
    chk("restart_state", int'(bus.game_state), 0);
    chk("restart_over", bus.game_over, 0);
    chk_home("restart");

    pulse_start();
    chk("run2_score", bus.score, 0);
    chk("run2_state", int'(bus.game_state), 1);
    bus.BirdX = 10'd688;
    bus.BirdY = 10'd72;
    bus.Bird_size = 10'd12;
    tick();
    chk("hit_state", int'(bus.game_state), 2);
    chk("hit_score", bus.score, 0);
    chk("hit_x0", bus.pipeX[0], 664);
    tick();
    chk("hit_frozen_x0", bus.pipeX[0], 664);
    chk("hit_frozen_x1", bus.pipeX[1], 824);

    bus.BirdX = 10'd100;
    bus.BirdY = 10'd240;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    repeat (3) tick();
    chk("pre_rst_x0", bus.pipeX[0], 658);
    chk("pre_rst_state", int'(bus.game_state), 1);
    #2 rst = 1'b1;
    #1;
    chk_home("mid_rst");
    chk("mid_rst_state", int'(bus.game_state), 0);
    chk("mid_rst_score", bus.score, 0);
    chk("mid_rst_over", bus.game_over, 0);
    chk("mid_rst_lfsr", dut.lfsr_q, 'hACE1);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/pipe_scheduler.md
# pipe_scheduler

Game-sequencing controller that owns the pipe field and score consumed by `color_mapper`. It scrolls four pipes leftward once per frame and recycles each pipe that leaves the screen with a pseudo-random gap. It awards BCD score as the bird clears each pipe, detects collisions, and runs the IDLE/RUN/DYING/OVER game state machine. It sits between the frame-rate timing and bird logic on one side and the color mapper's pipe and score inputs on the other.

## Interface
Parameters:
- `PIPE_W`, 24: pipe half-width, driven constant on `pipeWidth`.
- `GAP_HALF`, 50: gap half-height, driven constant on `pipeGapSize`.
- `SPACING`, 160: horizontal distance between consecutive pipes.
- `SPEED`, 2: pixels moved per frame.
- `GAP_MIN`, 120: smallest gap centre.
- `GAP_RANGE`, 240: gap centre span; centre is `GAP_MIN..GAP_MIN+GAP_RANGE-1`.
- `GROUND_Y`, 475: bird bottom at or below this value is a collision.
- `DYING_FRAMES`, 60: frames spent in DYING.
- `LFSR_SEED`, 16'hACE1: LFSR reset value, must be non-zero.

Ports:
- `Clk`  in  1  system clock.
- `Reset`  in  1  asynchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse per video frame, synchronous to `Clk`.
- `start`  in  1  one-cycle pulse from the flap key.
- `BirdX`, `BirdY`, `Bird_size`  in  10 each  bird centre and half-size.
- `pipeX`, `pipeWidth`, `pipeGapSize`, `pipeGapLocation`  out  [3:0][12:0] each  pipe descriptors.
- `score`  out  8  BCD; `[7:4]` tens, `[3:0]` ones.
- `game_state`  out  2  encoding `game_state_t`.
- `game_over`  out  1  high in OVER.

## Operation
- All outputs are registered.
- Reset values:
  - `pipeX[i] = 640 + PIPE_W + i*SPACING`, i.e. 664, 824, 984, 1144.
  - `pipeGapLocation[i] = 240`.
  - `score = 8'h00`, `game_state = IDLE`, `game_over = 0`.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every `Clk` cycle in every state.
- New gap value:
  - `r = lfsr[7:0]`; `off = (r >= GAP_RANGE) ? r - GAP_RANGE : r`.
  - `gap = GAP_MIN + off`, giving 120..359.
- IDLE:
  - Pipes are held at their reset values.
  - On `start`: go to RUN and clear `score` to 0.
- RUN: on each `frame_tick`, the steps below are evaluated on the pre-tick register values.
  1. Collision check. A collision is either of:
     - `BirdY + Bird_size >= GROUND_Y`.
     - Any pipe i where the X overlap (`BirdX + Bird_size > pipeX[i] - PIPE_W` and `BirdX - Bird_size < pipeX[i] + PIPE_W`) holds together with `BirdY - Bird_size < gap[i] - GAP_HALF` or `BirdY + Bird_size > gap[i] + GAP_HALF`.
     
     On collision: go to DYING, leave pipes and score unchanged, and clear the dying counter.
  2. Otherwise, for each pipe:
     - If `pipeX[i] < PIPE_W + SPEED`, recycle it: `pipeX[i] <= pipeX[(i+3)%4] + SPACING - SPEED` and `pipeGapLocation[i] <= gap`.
     - Else `pipeX[i] <= pipeX[i] - SPEED`.
  3. Score: a pipe is passed when `pipeX[i] + PIPE_W >= BirdX` and `pipeX[i] + PIPE_W - SPEED < BirdX`.
     - At most one increment per tick.
     - BCD increment: ones 9 wraps to 0 with a carry into tens. Saturates at 8'h99.
- `start` during RUN is ignored.
- DYING: pipes are frozen. Count `frame_tick`s; on the `DYING_FRAMES`-th tick go to OVER.
- OVER:
  - `game_over = 1`; `score` is held.
  - On `start`: go to IDLE and reload pipes to their reset values.
- All pipe arithmetic is 13-bit unsigned. The recycle rule guarantees no underflow.

## Timing
- Updates caused by a tick on cycle N are visible on cycle N+1.
- `start` and `frame_tick` in the same IDLE cycle: transition to RUN only, no pipe motion on that tick.
- Collision and score on the same tick: collision wins, no increment.
- Two pipes recycling on the same tick:
  - Cannot occur with the default parameters.
  - If it does, each uses its pre-tick predecessor and both take the same `gap`.
- `Reset` asserted mid-frame: all registers return to their reset values immediately; there is no partial update.

## Structure
- Package `flappy_pkg` holds:
  - `game_state_t` with `IDLE=0`, `RUN=1`, `DYING=2`, `OVER=3`.
  - `NUM_PIPES = 4`.
  - Screen constants (640, 480).
  - The parameter defaults.
- Sub-module `lfsr16` with ports `Clk`, `Reset`, `q[15:0]` and parameter seed.
- Pipe update uses a generate loop over `NUM_PIPES`.

## Test plan
- Reset, then `start`, then 1 tick with the bird at (100, 240, size 12) -> `pipeX` = 662, 822, 982, 1142; `score` = 0; `game_state` = RUN.
- Force `pipeX[0] = 25` (< 26) via preload, then tick -> `pipeX[0] = pipeX[3]_pre + 158`, and `pipeGapLocation[0]` in 120..359 matching the LFSR model.
- `BirdX = 100`, pipe right edge moving 101 -> 99 -> `score` 8'h00 -> 8'h01. From 8'h09 -> 8'h10. From 8'h99 stays 8'h99.
- Bird at y = 470 with size 6 (bottom 476 ≥ 475), then tick -> DYING. After 60 ticks -> OVER with `game_over = 1`. `start` -> IDLE with pipes at reset values.
- Bird overlapping a pipe in X with top 60 < gap 240 - 50 -> DYING on that tick; pipes unchanged afterwards.
- `Reset` pulsed in RUN between ticks -> next cycle all outputs at reset values and LFSR = `LFSR_SEED`.
